// File: rtl/axis_pkt_gen.sv
// AXI-Stream burst packet generator: emits pkt_num packets of pkt_len incrementing
// beats starting at seed, with an optional idle gap between packets.
module axis_pkt_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 12,
  parameter int CNT_WIDTH  = 8,
  parameter int GAP_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [CNT_WIDTH-1:0]  pkt_num,
  input  logic [GAP_WIDTH-1:0]  gap,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic [DATA_WIDTH-1:0] m_tdata_out,
  output logic                  m_tvalid_out,
  input  logic                  m_tready_in,
  output logic                  m_last_out,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  pkt_sent,
  output logic [1:0]            o_dbg_state
);

  // Stream handshake: a beat transfers on a rising edge where m_tvalid_out and
  // m_tready_in are both 1. Valid is registered and never looks at ready; once
  // raised, data/last/valid hold until the transfer happens.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t                r_state;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [CNT_WIDTH-1:0]  r_num;
  logic [GAP_WIDTH-1:0]  r_gap;
  logic [GAP_WIDTH-1:0]  r_gap_cnt;
  logic [LEN_WIDTH-1:0]  r_beat;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_last;
  logic                  r_busy;
  logic                  r_done;
  logic [CNT_WIDTH-1:0]  r_pkt_sent;

  logic                  w_hs;
  logic                  w_accept;
  logic [LEN_WIDTH-1:0]  w_beat_next;
  logic [LEN_WIDTH-1:0]  w_len_m1;
  logic [CNT_WIDTH-1:0]  w_pkt_next;
  logic                  w_final;

  assign w_hs        = r_valid & m_tready_in;
  assign w_accept    = start && (pkt_len != '0) && (pkt_num != '0);
  assign w_beat_next = r_beat + LEN_WIDTH'(1);
  assign w_len_m1    = r_len - LEN_WIDTH'(1);
  assign w_pkt_next  = r_pkt_sent + CNT_WIDTH'(1);
  // pkt_sent doubles as the packet index within the burst.
  assign w_final     = (w_pkt_next == r_num);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_num      <= '0;
      r_gap      <= '0;
      r_gap_cnt  <= '0;
      r_beat     <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pkt_sent <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_len      <= pkt_len;
            r_num      <= pkt_num;
            r_gap      <= gap;
            r_beat     <= '0;
            r_pkt_sent <= '0;
            r_data     <= seed;
            r_valid    <= 1'b1;
            r_last     <= (pkt_len == LEN_WIDTH'(1));
            r_busy     <= 1'b1;
            r_state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_hs) begin
            r_data <= r_data + DATA_WIDTH'(1);
            if (r_last) begin
              r_beat     <= '0;
              r_pkt_sent <= w_pkt_next;
              if (w_final) begin
                r_state <= ST_IDLE;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else if (r_gap == '0) begin
                r_last <= (r_len == LEN_WIDTH'(1));
              end else begin
                r_state   <= ST_GAP;
                r_valid   <= 1'b0;
                r_last    <= 1'b0;
                r_gap_cnt <= r_gap - GAP_WIDTH'(1);
              end
            end else begin
              r_beat <= w_beat_next;
              r_last <= (w_beat_next == w_len_m1);
            end
          end
        end
        ST_GAP: begin
          // Counter loaded with gap-1 so valid stays low for exactly gap cycles.
          if (r_gap_cnt == '0) begin
            r_state <= ST_SEND;
            r_valid <= 1'b1;
            r_last  <= (r_len == LEN_WIDTH'(1));
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_WIDTH'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign m_tdata_out  = r_data;
  assign m_tvalid_out = r_valid;
  assign m_last_out   = r_last;
  assign busy         = r_busy;
  assign done         = r_done;
  assign pkt_sent     = r_pkt_sent;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed bench for axis_pkt_gen: basic, wrap, gap, backpressure, ignored starts
// and asynchronous reset mid-packet.
module tb_axis_pkt_gen;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] pkt_len;
  logic [7:0]  pkt_num;
  logic [3:0]  gap;
  logic [7:0]  seed;
  logic [7:0]  m_tdata_out;
  logic        m_tvalid_out;
  logic        m_tready_in;
  logic        m_last_out;
  logic        busy;
  logic        done;
  logic [7:0]  pkt_sent;
  logic [1:0]  o_dbg_state;

  int checks = 0;
  int errors = 0;

  axis_pkt_gen dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .pkt_len      (pkt_len),
    .pkt_num      (pkt_num),
    .gap          (gap),
    .seed         (seed),
    .m_tdata_out  (m_tdata_out),
    .m_tvalid_out (m_tvalid_out),
    .m_tready_in  (m_tready_in),
    .m_last_out   (m_last_out),
    .busy         (busy),
    .done         (done),
    .pkt_sent     (pkt_sent),
    .o_dbg_state  (o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive config with start for one edge; the first beat must be visible right after.
  task automatic start_burst(input logic [11:0] len, input logic [7:0] num,
                             input logic [7:0] sd, input logic [3:0] g);
    pkt_len = len;
    pkt_num = num;
    seed    = sd;
    gap     = g;
    start   = 1'b1;
    step();
    start   = 1'b0;
    chk("start_busy",  busy, 1);
    chk("start_valid", m_tvalid_out, 1);
    chk("start_data",  m_tdata_out, sd);
    chk("start_psent", pkt_sent, 0);
  endtask

  // Walk the burst beat by beat. Beat k must carry sd+k and last exactly when
  // k is the final beat of a packet. Returns cycles from start to done and the
  // number of valid-low cycles seen on the way.
  task automatic drain(input int len, input int num, input logic [7:0] sd,
                       input bit rand_ready, output int cycles, output int idle);
    int total;
    int k;
    logic [7:0] exp_d;
    logic [7:0] prev_d;
    logic       prev_l;
    logic       stall;
    total  = len * num;
    k      = 0;
    cycles = 0;
    idle   = 0;
    while (k < total && cycles < 2000) begin
      m_tready_in = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_tvalid_out) begin
        exp_d = sd + 8'(k);
        chk("beat_data", m_tdata_out, exp_d);
        chk("beat_last", m_last_out, ((k % len) == len - 1) ? 1 : 0);
        chk("beat_busy", busy, 1);
      end else begin
        idle++;
      end
      stall  = m_tvalid_out && !m_tready_in;
      prev_d = m_tdata_out;
      prev_l = m_last_out;
      if (m_tvalid_out && m_tready_in) k++;
      step();
      cycles++;
      if (stall && k < total) begin
        chk("hold_valid", m_tvalid_out, 1);
        chk("hold_data",  m_tdata_out, prev_d);
        chk("hold_last",  m_last_out, prev_l);
      end
    end
    m_tready_in = 1'b1;
    chk("beats_done", k, total);
    chk("done_pulse", done, 1);
    chk("done_busy",  busy, 0);
    chk("done_valid", m_tvalid_out, 0);
    chk("done_psent", pkt_sent, num);
  endtask

  initial begin
    int cyc;
    int idl;
    rst         = 1'b0;
    start       = 1'b0;
    pkt_len     = '0;
    pkt_num     = '0;
    gap         = '0;
    seed        = '0;
    m_tready_in = 1'b1;
    #2;
    chk("rst_valid", m_tvalid_out, 0);
    chk("rst_last",  m_last_out, 0);
    chk("rst_data",  m_tdata_out, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_psent", pkt_sent, 0);
    step();
    step();
    rst = 1'b1;
    step();

    // basic: F0..F3, last on F3, one done
    start_burst(12'd4, 8'd1, 8'hF0, 4'd0);
    drain(4, 1, 8'hF0, 1'b0, cyc, idl);
    chk("basic_cycles", cyc, 4);
    step();
    chk("basic_done_once", done, 0);
    chk("basic_psent_hold", pkt_sent, 1);

    // wrap and back-to-back: FE..06, no bubbles
    start_burst(12'd3, 8'd3, 8'hFE, 4'd0);
    drain(3, 3, 8'hFE, 1'b0, cyc, idl);
    chk("wrap_cycles", cyc, 9);
    chk("wrap_idle", idl, 0);
    step();

    // gap of 3 between two 2-beat packets: 7 cycles total
    start_burst(12'd2, 8'd2, 8'h10, 4'd3);
    drain(2, 2, 8'h10, 1'b0, cyc, idl);
    chk("gap_idle", idl, 3);
    chk("gap_cycles", cyc, 7);
    step();

    // backpressure: random ready, 2 packets of 5, gap 1
    start_burst(12'd5, 8'd2, 8'h30, 4'd1);
    drain(5, 2, 8'h30, 1'b1, cyc, idl);
    chk("bp_idle", idl, 1);
    step();

    // ignored starts: zero length, zero count
    pkt_len = 12'd0; pkt_num = 8'd2; seed = 8'h77; start = 1'b1;
    step();
    start = 1'b0;
    chk("len0_busy",  busy, 0);
    chk("len0_valid", m_tvalid_out, 0);
    step();
    chk("len0_done",  done, 0);
    pkt_len = 12'd3; pkt_num = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("num0_busy",  busy, 0);
    chk("num0_valid", m_tvalid_out, 0);
    chk("num0_state", o_dbg_state, 0);

    // start held with new config while busy must not disturb the burst
    start_burst(12'd4, 8'd1, 8'h40, 4'd0);
    pkt_len = 12'd7; pkt_num = 8'd5; seed = 8'h99; gap = 4'd2; start = 1'b1;
    drain(4, 1, 8'h40, 1'b0, cyc, idl);
    start = 1'b0;
    step();
    chk("busy_start_done", done, 0);
    chk("busy_start_idle", busy, 0);

    // asynchronous reset during beat 2 of 4
    start_burst(12'd4, 8'd1, 8'h55, 4'd0);
    step();
    step();
    chk("pre_rst_data", m_tdata_out, 8'h57);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", m_tvalid_out, 0);
    chk("arst_last",  m_last_out, 0);
    chk("arst_busy",  busy, 0);
    chk("arst_data",  m_tdata_out, 0);
    chk("arst_state", o_dbg_state, 0);
    #2;
    rst = 1'b1;
    step();
    chk("post_rst_valid", m_tvalid_out, 0);
    chk("post_rst_state", o_dbg_state, 0);
    start_burst(12'd4, 8'd1, 8'h55, 4'd0);
    drain(4, 1, 8'h55, 1'b0, cyc, idl);
    chk("post_rst_cycles", cyc, 4);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
